// File: rtl/adc_sample_ctrl.sv
// rtl/adc_sample_ctrl.sv - serial ADC sampler feeding the Kalman filter stage
//
// Purpose: on each sample tick, runs one 16-clock MSB-first frame on a 12-bit
// serial ADC, publishes the code on origin_data, holds it for SETTLE cycles,
// strobes en_kalman and waits for filter_finish (bounded by ACK_TIMEOUT).
//
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   start_en        enables the periodic sample tick
//   adc_sdo         ADC serial data in
//   filter_finish   acknowledge from the filter
//   adc_cs_n        ADC chip select (active low)
//   adc_sclk        ADC serial clock, idles high
//   origin_data     last accepted 12-bit sample
//   en_kalman       one-cycle strobe to the filter
//   busy            high outside IDLE
//   overrun         pulse: tick arrived while busy (tick dropped)
//   ack_err         pulse: filter_finish timed out
//   frame_err       pulse: leading nibble non-zero (checked build only)
//
// Build option: ADC_FRAME_CHECK_EN enables the leading-zero frame check.

module adc_sample_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int SAMPLE_PERIOD = 50000,
  parameter int SETTLE        = 8,
  parameter int ACK_TIMEOUT   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_en,
  input  logic        adc_sdo,
  input  logic        filter_finish,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [11:0] origin_data,
  output logic        en_kalman,
  output logic        busy,
  output logic        overrun,
  output logic        ack_err,
  output logic        frame_err
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int AW = $clog2(ACK_TIMEOUT + 1);
`ifdef ADC_FRAME_CHECK_EN
  localparam int SW = 16;
`else
  // Leading bits are ignored, so they simply fall off the top of a 12-bit shifter.
  localparam int SW = 12;
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_CONV, S_LOAD, S_SETTLE, S_STROBE, S_WAIT_ACK
  } state_t;

  state_t          state_q, state_d;
  logic [TW-1:0]   tick_cnt_q;
  logic [7:0]      div_cnt_q, div_cnt_d;
  logic [5:0]      tog_cnt_q, tog_cnt_d;
  logic            sclk_q, sclk_d;
  logic [SW-1:0]   shift_q, shift_d;
  logic [11:0]     origin_q, origin_d;
  logic [7:0]      set_cnt_q, set_cnt_d;
  logic [AW-1:0]   ack_cnt_q, ack_cnt_d;
  logic            tick;
  logic            frame_ok;
  logic            frame_err_c;

  assign tick = start_en && (tick_cnt_q == TW'(SAMPLE_PERIOD - 1));

`ifdef ADC_FRAME_CHECK_EN
  assign frame_ok = (shift_q[15:12] == 4'b0000);
`else
  assign frame_ok = 1'b1;
`endif

  // The tail CONV cycle (32 toggles done) already has chip select released,
  // giving exactly 32*CLK_DIV low cycles while the last rising edge settles.
  assign adc_cs_n    = !((state_q == S_CONV) && (tog_cnt_q != 6'd32));
  assign adc_sclk    = sclk_q;
  assign origin_data = origin_q;
  assign busy        = (state_q != S_IDLE);
  assign overrun     = tick && busy;
  assign frame_err   = frame_err_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      tick_cnt_q <= '0;
      div_cnt_q  <= '0;
      tog_cnt_q  <= '0;
      sclk_q     <= 1'b1;
      shift_q    <= '0;
      origin_q   <= '0;
      set_cnt_q  <= '0;
      ack_cnt_q  <= '0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= (!start_en || tick) ? '0 : tick_cnt_q + 1'b1;
      div_cnt_q  <= div_cnt_d;
      tog_cnt_q  <= tog_cnt_d;
      sclk_q     <= sclk_d;
      shift_q    <= shift_d;
      origin_q   <= origin_d;
      set_cnt_q  <= set_cnt_d;
      ack_cnt_q  <= ack_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    div_cnt_d   = div_cnt_q;
    tog_cnt_d   = tog_cnt_q;
    sclk_d      = sclk_q;
    shift_d     = shift_q;
    origin_d    = origin_q;
    set_cnt_d   = set_cnt_q;
    ack_cnt_d   = ack_cnt_q;
    en_kalman   = 1'b0;
    ack_err     = 1'b0;
    frame_err_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d   = S_CONV;
          div_cnt_d = '0;
          tog_cnt_d = '0;
          sclk_d    = 1'b1;
        end
      end

      S_CONV: begin
        if (tog_cnt_q == 6'd32) begin
          // Shifter is final here; publish so the code is visible during LOAD.
          state_d   = S_LOAD;
          div_cnt_d = '0;
          tog_cnt_d = '0;
          if (frame_ok) origin_d = shift_q[11:0];
        end else if (div_cnt_q == 8'(CLK_DIV - 1)) begin
          div_cnt_d = '0;
          tog_cnt_d = tog_cnt_q + 6'd1;
          sclk_d    = ~sclk_q;
          // Sample on the edge that drives sclk high.
          if (!sclk_q) shift_d = {shift_q[SW-2:0], adc_sdo};
        end else begin
          div_cnt_d = div_cnt_q + 8'd1;
        end
      end

      S_LOAD: begin
        set_cnt_d = '0;
        state_d   = S_SETTLE;
        if (!frame_ok) begin
          frame_err_c = 1'b1;
          state_d     = S_IDLE;
        end
      end

      S_SETTLE: begin
        if (set_cnt_q == 8'(SETTLE - 1)) state_d = S_STROBE;
        else set_cnt_d = set_cnt_q + 8'd1;
      end

      S_STROBE: begin
        en_kalman = 1'b1;
        ack_cnt_d = '0;
        state_d   = S_WAIT_ACK;
      end

      S_WAIT_ACK: begin
        if (filter_finish) begin
          state_d = S_IDLE;
        end else if (ack_cnt_q == AW'(ACK_TIMEOUT - 1)) begin
          ack_err = 1'b1;
          state_d = S_IDLE;
        end else begin
          ack_cnt_d = ack_cnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_sample_ctrl.sv
// tb/tb_adc_sample_ctrl.sv - randomized self-checking bench for adc_sample_ctrl

module tb_adc_sample_ctrl;

  localparam int CD       = 4;
  localparam int SP       = 150;
  localparam int ST       = 8;
  localparam int AT       = 16;
  localparam int LOAD_D   = 32 * CD + 2;
  localparam int STROBE_D = LOAD_D + ST + 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_en = 1'b0;
  logic        adc_sdo = 1'b0;
  logic        filter_finish = 1'b0;
  logic        adc_cs_n;
  logic        adc_sclk;
  logic [11:0] origin_data;
  logic        en_kalman;
  logic        busy;
  logic        overrun;
  logic        ack_err;
  logic        frame_err;

  always #5 clk = ~clk;

  adc_sample_ctrl #(
    .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .SETTLE(ST), .ACK_TIMEOUT(AT)
  ) dut (
    .clk(clk), .rst(rst), .start_en(start_en), .adc_sdo(adc_sdo),
    .filter_finish(filter_finish), .adc_cs_n(adc_cs_n), .adc_sclk(adc_sclk),
    .origin_data(origin_data), .en_kalman(en_kalman), .busy(busy),
    .overrun(overrun), .ack_err(ack_err), .frame_err(frame_err)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Serial ADC model: presents the next bit after every falling sclk edge.
  logic [15:0] cur_word = 16'h0;
  int          bit_idx  = -1;
  always @(negedge adc_cs_n) bit_idx = 15;
  always @(negedge adc_sclk) begin
    if (bit_idx >= 0) begin
      adc_sdo = cur_word[bit_idx];
      bit_idx--;
    end
  end

  typedef struct { logic [15:0] word; int ack; } frame_t;
  frame_t force_q[$];

  // Reference model: conversion described by its tick cycle and offsets from it.
  bit          se_req = 1'b0, rst_req = 1'b1;
  int          base = 0;
  bit          act = 1'b0, good = 1'b1;
  int          t0 = 0, s_cyc = 0, e_cyc = 0, ack_j = 0;
  logic [11:0] org_exp = 12'h0;
  bit          prev_cs = 1'b1, prev_sclk = 1'b1, win = 1'b0, aborted = 1'b0;
  int          cs_len = 0, rises = 0;

  task automatic cycle();
    int     d;
    bit     tick, ackv, in_frame;
    bit     cs_e, sc_e, en_e, ae_e, fe_e, ov_e;
    frame_t f;
    @(posedge clk);
    cyc++;
    #1;
    rst           = rst_req;
    start_en      = se_req;
    filter_finish = act && (ack_j >= 1) && (ack_j <= AT) && (cyc == s_cyc + ack_j);
    if (rst_req) aborted = 1'b1;
    @(negedge clk);

    if (act && cyc >= e_cyc) act = 1'b0;
    d        = cyc - t0;
    tick     = start_en && ((cyc - base) % SP == SP - 1);
    ackv     = (ack_j >= 1) && (ack_j <= AT);
    in_frame = act && (d >= 1) && (d <= 32 * CD);
    cs_e     = !in_frame;
    sc_e     = in_frame ? (((d - 1) / CD) % 2 == 0) : 1'b1;
    if (act && good && d == LOAD_D) org_exp = cur_word[11:0];
    en_e = act && good && (d == STROBE_D);
    ae_e = act && good && !ackv && (cyc == s_cyc + AT);
    fe_e = act && !good && (d == LOAD_D);
    ov_e = tick && act;

    check_eq("cs_n", adc_cs_n, cs_e);
    check_eq("sclk", adc_sclk, sc_e);
    check_eq("origin", origin_data, org_exp);
    check_eq("en_kalman", en_kalman, en_e);
    check_eq("busy", busy, act);
    check_eq("overrun", overrun, ov_e);
    check_eq("ack_err", ack_err, ae_e);
    check_eq("frame_err", frame_err, fe_e);

    // Frame shape measured from the pins themselves.
    if (prev_cs && !adc_cs_n) begin
      win = 1'b1; aborted = 1'b0; cs_len = 0; rises = 0;
    end
    if (win) begin
      if (!adc_cs_n) cs_len++;
      if (!prev_sclk && adc_sclk) rises++;
      if (!prev_cs && adc_cs_n) begin
        if (!aborted) begin
          check_eq("cs_low_len", cs_len, 32 * CD);
          check_eq("sclk_rises", rises, 16);
        end
        win = 1'b0;
      end
    end
    prev_cs   = adc_cs_n;
    prev_sclk = adc_sclk;

    if (rst) begin
      act = 1'b0; org_exp = 12'h0; base = cyc + 1;
    end else begin
      if (!start_en) base = cyc + 1;
      if (tick && !act) begin
        t0 = cyc; act = 1'b1;
        if (force_q.size() > 0) begin
          f = force_q.pop_front();
          cur_word = f.word; ack_j = f.ack;
        end else begin
          cur_word = {($urandom_range(0, 3) == 0) ? 4'($urandom_range(1, 15)) : 4'h0, 12'($urandom)};
          ack_j    = $urandom_range(0, AT + 2);
        end
`ifdef ADC_FRAME_CHECK_EN
        good = (cur_word[15:12] == 4'h0);
`else
        good = 1'b1;
`endif
        s_cyc = t0 + STROBE_D;
        if (!good) e_cyc = t0 + LOAD_D + 1;
        else if (ack_j >= 1 && ack_j <= AT) e_cyc = s_cyc + ack_j + 1;
        else e_cyc = s_cyc + AT + 1;
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic run_rand(input int n);
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 299) == 0) se_req = !se_req;
      cycle();
    end
  endtask

  task automatic wait_d(input int target);
    int lim;
    lim = 0;
    while (!(act && (cyc - t0) == target) && lim < 4 * SP) begin
      cycle();
      lim++;
    end
    check_eq("wait_offset", act ? (cyc - t0) : -1, target);
  endtask

  task automatic wait_forced();
    int lim;
    lim = 0;
    while (force_q.size() > 0 && lim < 4 * SP) begin
      cycle();
      lim++;
    end
    check_eq("forced_taken", force_q.size(), 0);
  endtask

  initial begin
    frame_t f;
    rst_req = 1'b1;
    run(3);
    rst_req = 1'b0;
    run(2);
    check_eq("rst_cs_n", adc_cs_n, 1'b1);
    check_eq("rst_sclk", adc_sclk, 1'b1);
    check_eq("rst_origin", origin_data, 12'h000);
    check_eq("rst_busy", busy, 1'b0);

    // First conversion 0x0ABC with immediate acknowledge.
    f.word = 16'h0ABC; f.ack = 1;
    force_q.push_back(f);
    se_req = 1'b1;
    wait_forced();
    wait_d(LOAD_D);
    check_eq("first_origin", origin_data, 12'hABC);
    wait_d(STROBE_D);
    check_eq("first_strobe", en_kalman, 1'b1);
    run(2);
    check_eq("first_idle", busy, 1'b0);

    run(8 * SP);

    // Frame with non-zero leading nibble.
    f.word = 16'h8123; f.ack = 2;
    force_q.push_back(f);
    wait_forced();
    wait_d(LOAD_D);
`ifdef ADC_FRAME_CHECK_EN
    check_eq("bad_frame_err", frame_err, 1'b1);
    check_eq("bad_frame_origin", origin_data, org_exp);
`else
    check_eq("bad_frame_err", frame_err, 1'b0);
    check_eq("bad_frame_origin", origin_data, 12'h123);
    wait_d(STROBE_D);
    check_eq("bad_frame_strobe", en_kalman, 1'b1);
`endif
    run(3 * SP);

    // Drop start_en mid-conversion: frame finishes, then silence.
    wait_d(50);
    se_req = 1'b0;
    run(4 * SP);
    check_eq("stopped_busy", busy, 1'b0);

    // Reset in the middle of a frame.
    se_req = 1'b1;
    run(2 * SP);
    wait_d(60);
    rst_req = 1'b1;
    cycle();
    rst_req = 1'b0;
    cycle();
    check_eq("midrst_cs_n", adc_cs_n, 1'b1);
    check_eq("midrst_sclk", adc_sclk, 1'b1);
    check_eq("midrst_origin", origin_data, 12'h000);
    run(3 * SP);

    run_rand(12 * SP);
    se_req = 1'b1;
    run(4 * SP);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
